atp_multi_tender: RTL and testbench
===================================

ATP_MULTI_TENDER -- requirements
Module: atp_multi_tender

Interface
REQ-001 The block SHALL have parameter AMT_W, default 16, meaning the width of every amount.
REQ-002 The block SHALL have parameter NCH, default 4, meaning the number of tender channels (cheque, DD, card, currency, ...).
REQ-003 The block SHALL have parameter TIMEOUT, default 1024, meaning the COLLECT cycles allowed without an accepted tender.
REQ-004 The block SHALL have parameter MAX_TENDERS, default 8, meaning the maximum accepted tenders per transaction.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit: reset, synchronous, active-low.
REQ-007 The block SHALL have port start_payment, input, 1 bit: start a transaction, sampled in IDLE only.
REQ-008 The block SHALL have port bill_amount, input, AMT_W bits: amount due, latched on start.
REQ-009 The block SHALL have port cancel, input, 1 bit: customer abort.
REQ-010 The block SHALL have port tender_valid, input, NCH bits: per-channel tender present.
REQ-011 The block SHALL have port tender_amount, input, NCH*AMT_W bits: packed amounts; channel i at bits [i*AMT_W +: AMT_W].
REQ-012 The block SHALL have port tender_ready, output, 1 bit: high in COLLECT.
REQ-013 The block SHALL have port tender_accept, output, NCH bits: one-hot pulse, one cycle, for the accepted channel.
REQ-014 The block SHALL have port err_reject, output, 1 bit: one-cycle pulse on any rejected start or tender.
REQ-015 The block SHALL have ports paid_amount, remaining_amount and change_amount, each output, AMT_W bits.
REQ-016 The block SHALL have ports payment_complete and line_disconnected, each output, 1 bit, and busy, output, 1 bit (high outside IDLE).

Function
REQ-017 The FSM SHALL have states IDLE, COLLECT, DONE and ABORT.
REQ-018 In IDLE, start_payment=1 with bill_amount!=0 SHALL cause the following:
- latch the bill;
- set paid=0 and remaining=bill;
- clear change_amount, payment_complete and line_disconnected;
- go to COLLECT at the next edge.
REQ-019 In IDLE, start_payment=1 with bill_amount=0 SHALL pulse err_reject and remain in IDLE.
REQ-020 start_payment outside IDLE SHALL be ignored.
REQ-021 In COLLECT, when several tender_valid bits are set, the lowest index SHALL win; other channels are neither accepted nor rejected.
REQ-022 A winning tender SHALL be rejected (err_reject pulse, no accept, paid unchanged) if any of the following holds:
- the amount is 0;
- paid+amount exceeds 2^AMT_W-1 (computed at AMT_W+1 bits);
- MAX_TENDERS have already been accepted.
REQ-023 An accepted tender at edge k SHALL take effect at that same edge:
- paid <= paid+amount;
- remaining <= max(bill-paid_new, 0), saturating;
- tender_accept[i] high for the cycle after edge k;
- the timeout counter clears.
REQ-024 If the new paid is at least bill at edge k, then at the same edge k:
- the state SHALL go to DONE;
- change_amount SHALL be set to paid-bill;
- payment_complete SHALL be set to 1.
REQ-025 DONE SHALL last one cycle and then go to IDLE; payment_complete SHALL pulse for one cycle; paid, remaining and change SHALL hold until the next start.
REQ-026 cancel=1 in COLLECT SHALL move the FSM to ABORT and SHALL take priority over a same-cycle tender, which is not accepted.
REQ-027 The timeout counter SHALL increment on each COLLECT cycle with no acceptance; reaching TIMEOUT SHALL cause the following:
- go to ABORT;
- set line_disconnected=1, held until the next accepted start.
REQ-028 ABORT SHALL last one cycle and then go to IDLE; the refund SHALL be reported per REQ-033.
REQ-029 The tender accept count and the timeout counter SHALL clear on every start.

Reset
REQ-030 While reset_n=0 at a clock edge, the block SHALL apply the following, overriding all other inputs:
- state <= IDLE;
- all amounts, counters and outputs <= 0.
REQ-031 Reset asserted mid-transaction SHALL discard the transaction with no refund report; the first start is accepted one cycle after reset_n returns to 1.

Configuration
REQ-032 With macro ATP_CHANGE_EN defined, overpayment SHALL be accepted and change computed per REQ-024.
REQ-033 With ATP_CHANGE_EN defined, cancel or timeout SHALL set change_amount to paid (the refund).
REQ-034 Without ATP_CHANGE_EN, a tender making paid greater than bill SHALL be rejected per REQ-022.
REQ-035 Without ATP_CHANGE_EN, change_amount SHALL be tied to 0 and completion requires paid equal to bill exactly.

Verification
REQ-036 Bill 100, tenders ch1=40, ch3=60 -> accepts pulse, paid 40 then 100, remaining 60 then 0, payment_complete pulse, change 0.
REQ-037 With ATP_CHANGE_EN: bill 100, ch0=150 -> change 50, DONE. Without it: err_reject pulse, paid 0, remaining 100.
REQ-038 Bill 100, ch0=30 and ch2=50 valid together -> only ch0 accepted, paid 30; ch2 next cycle -> paid 80.
REQ-039 Bill 100, ch0=20, then idle TIMEOUT cycles -> ABORT, line_disconnected=1, change 20 (CHANGE_EN).
REQ-040 Tender and cancel in the same cycle -> no accept, ABORT. Tender of amount 0 -> err_reject. Bill 0 -> err_reject, stays IDLE.
REQ-041 reset_n=0 mid-COLLECT with paid=50 -> all outputs 0, IDLE; a new start one cycle after release is accepted.

Source files
------------

// File: rtl/atp_multi_tender.sv
// Multi-tender payment collector: gathers tenders from NCH channels toward a bill, then completes or aborts.
// Optional overpayment/change/refund support is enabled with macro ATP_CHANGE_EN.
module atp_multi_tender #(
    parameter int unsigned AMT_W       = 16,
    parameter int unsigned NCH         = 4,
    parameter int unsigned TIMEOUT     = 1024,
    parameter int unsigned MAX_TENDERS = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start_payment,
    input  logic [AMT_W-1:0]     bill_amount,
    input  logic                 cancel,
    input  logic [NCH-1:0]       tender_valid,
    input  logic [NCH*AMT_W-1:0] tender_amount,
    output logic                 tender_ready,
    output logic [NCH-1:0]       tender_accept,
    output logic                 err_reject,
    output logic [AMT_W-1:0]     paid_amount,
    output logic [AMT_W-1:0]     remaining_amount,
    output logic [AMT_W-1:0]     change_amount,
    output logic                 payment_complete,
    output logic                 line_disconnected,
    output logic                 busy
);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned CW = $clog2(MAX_TENDERS + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE, ABORT} state_t;

    state_t           state_q, state_d;
    logic [AMT_W-1:0] bill_q, bill_d;
    logic [AMT_W-1:0] paid_q, paid_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic [AMT_W-1:0] change_q, change_d;
    logic [NCH-1:0]   accept_q, accept_d;
    logic             err_q, err_d;
    logic             complete_q, complete_d;
    logic             disc_q, disc_d;
    logic [CW-1:0]    count_q, count_d;
    logic [TW-1:0]    timer_q, timer_d;

    logic             win_hit;
    logic [NCH-1:0]   win_oh;
    logic [AMT_W-1:0] win_amt;
    logic [AMT_W:0]   sum;
    logic [AMT_W-1:0] paid_new;
    logic             over;
    logic             done_hit;
    logic             abort_go;

    // Lowest-index valid channel wins.
    always_comb begin
        win_hit = 1'b0;
        win_oh  = '0;
        win_amt = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (tender_valid[i]) begin
                win_hit    = 1'b1;
                win_oh     = '0;
                win_oh[i]  = 1'b1;
                win_amt    = tender_amount[i*AMT_W +: AMT_W];
            end
        end
    end

    always_comb begin
        sum      = {1'b0, paid_q} + {1'b0, win_amt};
        paid_new = sum[AMT_W-1:0];
`ifdef ATP_CHANGE_EN
        over     = sum[AMT_W];
        done_hit = paid_new >= bill_q;
`else
        over     = sum[AMT_W] | (sum > {1'b0, bill_q});
        done_hit = paid_new == bill_q;
`endif
    end

    always_comb begin
        state_d    = state_q;
        bill_d     = bill_q;
        paid_d     = paid_q;
        rem_d      = rem_q;
        change_d   = change_q;
        accept_d   = '0;
        err_d      = 1'b0;
        complete_d = 1'b0;
        disc_d     = disc_q;
        count_d    = count_q;
        timer_d    = timer_q;
        abort_go   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_payment) begin
                    if (bill_amount == '0) begin
                        err_d = 1'b1;
                    end else begin
                        bill_d   = bill_amount;
                        paid_d   = '0;
                        rem_d    = bill_amount;
                        change_d = '0;
                        disc_d   = 1'b0;
                        count_d  = '0;
                        timer_d  = '0;
                        state_d  = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (cancel) begin
                    state_d  = ABORT;
                    abort_go = 1'b1;
                end else if (win_hit && win_amt != '0 && !over &&
                             count_q != CW'(MAX_TENDERS)) begin
                    accept_d = win_oh;
                    paid_d   = paid_new;
                    rem_d    = (bill_q > paid_new) ? bill_q - paid_new : '0;
                    count_d  = count_q + CW'(1);
                    timer_d  = '0;
                    if (done_hit) begin
                        state_d    = DONE;
                        change_d   = paid_new - bill_q;
                        complete_d = 1'b1;
                    end
                end else begin
                    err_d   = win_hit;
                    timer_d = timer_q + TW'(1);
                    if (timer_d == TW'(TIMEOUT)) begin
                        state_d  = ABORT;
                        disc_d   = 1'b1;
                        abort_go = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

`ifdef ATP_CHANGE_EN
        if (abort_go) change_d = paid_q;
`else
        change_d = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            bill_q     <= '0;
            paid_q     <= '0;
            rem_q      <= '0;
            change_q   <= '0;
            accept_q   <= '0;
            err_q      <= 1'b0;
            complete_q <= 1'b0;
            disc_q     <= 1'b0;
            count_q    <= '0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            bill_q     <= bill_d;
            paid_q     <= paid_d;
            rem_q      <= rem_d;
            change_q   <= change_d;
            accept_q   <= accept_d;
            err_q      <= err_d;
            complete_q <= complete_d;
            disc_q     <= disc_d;
            count_q    <= count_d;
            timer_q    <= timer_d;
        end
    end

    assign tender_ready      = (state_q == COLLECT);
    assign busy              = (state_q != IDLE);
    assign tender_accept     = accept_q;
    assign err_reject        = err_q;
    assign paid_amount       = paid_q;
    assign remaining_amount  = rem_q;
    assign change_amount     = change_q;
    assign payment_complete  = complete_q;
    assign line_disconnected = disc_q;

endmodule

// File: tb/tb_atp_multi_tender.sv
// Directed vector bench for atp_multi_tender (expectations follow ATP_CHANGE_EN when defined).
module tb_atp_multi_tender;
    localparam int unsigned TIMEOUT = 20;
    localparam int unsigned MAXT    = 3;
`ifdef ATP_CHANGE_EN
    localparam bit CHG = 1'b1;
`else
    localparam bit CHG = 1'b0;
`endif

    typedef struct packed {
        logic        rst_n;
        logic        start;
        logic [15:0] bill;
        logic        cancel;
        logic [3:0]  valid;
        logic [63:0] amt;
    } in_t;

    typedef struct packed {
        logic        ready;
        logic [3:0]  acc;
        logic        err;
        logic [15:0] paid;
        logic [15:0] rem;
        logic [15:0] chg;
        logic        cmp;
        logic        disc;
        logic        busy;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start_payment;
    logic [15:0] bill_amount;
    logic        cancel;
    logic [3:0]  tender_valid;
    logic [63:0] tender_amount;
    logic        tender_ready;
    logic [3:0]  tender_accept;
    logic        err_reject;
    logic [15:0] paid_amount;
    logic [15:0] remaining_amount;
    logic [15:0] change_amount;
    logic        payment_complete;
    logic        line_disconnected;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    atp_multi_tender #(
        .AMT_W(16), .NCH(4), .TIMEOUT(TIMEOUT), .MAX_TENDERS(MAXT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start_payment(start_payment),
        .bill_amount(bill_amount), .cancel(cancel), .tender_valid(tender_valid),
        .tender_amount(tender_amount), .tender_ready(tender_ready),
        .tender_accept(tender_accept), .err_reject(err_reject),
        .paid_amount(paid_amount), .remaining_amount(remaining_amount),
        .change_amount(change_amount), .payment_complete(payment_complete),
        .line_disconnected(line_disconnected), .busy(busy)
    );

    function automatic in_t mk_in(input logic r, input logic s, input int b, input logic c,
                                  input logic [3:0] v, input int a0, input int a1,
                                  input int a2, input int a3);
        in_t x;
        x.rst_n = r; x.start = s; x.bill = 16'(b); x.cancel = c; x.valid = v;
        x.amt = {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
        return x;
    endfunction

    function automatic out_t mk_out(input logic rd, input logic [3:0] ac, input logic er,
                                    input int p, input int rm, input int ch,
                                    input logic cp, input logic dc, input logic bs);
        out_t x;
        x.ready = rd; x.acc = ac; x.err = er; x.paid = 16'(p); x.rem = 16'(rm);
        x.chg = 16'(ch); x.cmp = cp; x.disc = dc; x.busy = bs;
        return x;
    endfunction

    task automatic add(input in_t i, input out_t o);
        vec_t v;
        v.i = i; v.o = o;
        tbl.push_back(v);
    endtask

    task automatic drive(input in_t i);
        reset_n = i.rst_n; start_payment = i.start; bill_amount = i.bill;
        cancel = i.cancel; tender_valid = i.valid; tender_amount = i.amt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic out_t sample();
        return mk_out(tender_ready, tender_accept, err_reject, int'(paid_amount),
                      int'(remaining_amount), int'(change_amount), payment_complete,
                      line_disconnected, busy);
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    initial begin
        int n;
        int r80;
        out_t act;
        r80 = CHG ? 80 : 0;
        drive(mk_in(0, 0, 0, 0, 4'b0000, 0, 0, 0, 0));

        add(mk_in(0,0,0,0,4'b0000,0,0,0,0),    mk_out(0,4'h0,0,0,0,0,0,0,0));
        add(mk_in(0,1,77,0,4'b0001,5,0,0,0),   mk_out(0,4'h0,0,0,0,0,0,0,0));
        add(mk_in(1,1,100,0,4'b0000,0,0,0,0),  mk_out(1,4'h0,0,0,100,0,0,0,1));
        add(mk_in(1,0,0,0,4'b0010,0,40,0,0),   mk_out(1,4'h2,0,40,60,0,0,0,1));
        add(mk_in(1,0,0,0,4'b1000,0,0,0,60),   mk_out(0,4'h8,0,100,0,0,1,0,1));
        add(mk_in(1,0,0,0,4'b0000,0,0,0,0),    mk_out(0,4'h0,0,100,0,0,0,0,0));
        add(mk_in(1,1,100,0,4'b0000,0,0,0,0),  mk_out(1,4'h0,0,0,100,0,0,0,1));
        add(mk_in(1,0,0,0,4'b0101,30,0,50,0),  mk_out(1,4'h1,0,30,70,0,0,0,1));
        add(mk_in(1,0,0,0,4'b0100,0,0,50,0),   mk_out(1,4'h4,0,80,20,0,0,0,1));
        add(mk_in(1,0,0,1,4'b0001,20,0,0,0),   mk_out(0,4'h0,0,80,20,r80,0,0,1));
        add(mk_in(1,0,0,0,4'b0000,0,0,0,0),    mk_out(0,4'h0,0,80,20,r80,0,0,0));
        add(mk_in(1,1,0,0,4'b0000,0,0,0,0),    mk_out(0,4'h0,1,80,20,r80,0,0,0));
        add(mk_in(1,1,100,0,4'b0000,0,0,0,0),  mk_out(1,4'h0,0,0,100,0,0,0,1));
        add(mk_in(1,1,5,0,4'b0000,0,0,0,0),    mk_out(1,4'h0,0,0,100,0,0,0,1));
        add(mk_in(1,0,0,0,4'b0001,0,0,0,0),    mk_out(1,4'h0,1,0,100,0,0,0,1));
        add(mk_in(1,0,0,0,4'b0001,10,0,0,0),   mk_out(1,4'h1,0,10,90,0,0,0,1));
        add(mk_in(1,0,0,0,4'b0001,10,0,0,0),   mk_out(1,4'h1,0,20,80,0,0,0,1));
        add(mk_in(1,0,0,0,4'b0001,10,0,0,0),   mk_out(1,4'h1,0,30,70,0,0,0,1));
        add(mk_in(1,0,0,0,4'b0001,10,0,0,0),   mk_out(1,4'h0,1,30,70,0,0,0,1));
        add(mk_in(0,0,0,0,4'b0001,10,0,0,0),   mk_out(0,4'h0,0,0,0,0,0,0,0));
        add(mk_in(1,1,100,0,4'b0000,0,0,0,0),  mk_out(1,4'h0,0,0,100,0,0,0,1));
        add(mk_in(1,0,0,1,4'b0000,0,0,0,0),    mk_out(0,4'h0,0,0,100,0,0,0,1));
        add(mk_in(1,0,0,0,4'b0000,0,0,0,0),    mk_out(0,4'h0,0,0,100,0,0,0,0));

        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k].i);
            step();
            act = sample();
            n_cmp++;
            if (act !== tbl[k].o) begin
                n_bad++;
                $display("FAIL vec%0d: got %h expected %h", k, act, tbl[k].o);
            end
        end

        // Overpayment by a single tender.
        drive(mk_in(1,1,100,0,4'b0000,0,0,0,0));
        step();
        drive(mk_in(1,0,0,0,4'b0001,150,0,0,0));
        step();
        check("over_acc",  int'(tender_accept), CHG ? 1 : 0);
        check("over_err",  int'(err_reject), CHG ? 0 : 1);
        check("over_paid", int'(paid_amount), CHG ? 150 : 0);
        check("over_rem",  int'(remaining_amount), CHG ? 0 : 100);
        check("over_chg",  int'(change_amount), CHG ? 50 : 0);
        check("over_cmp",  int'(payment_complete), CHG ? 1 : 0);
        drive(mk_in(1,0,0,1,4'b0000,0,0,0,0));
        step();
        drive(mk_in(1,0,0,0,4'b0000,0,0,0,0));
        step();
        step();
        check("over_idle", int'(busy), 0);

        // Sum overflowing AMT_W bits is rejected.
        drive(mk_in(1,1,65535,0,4'b0000,0,0,0,0));
        step();
        drive(mk_in(1,0,0,0,4'b0010,0,65000,0,0));
        step();
        check("ovf_paid1", int'(paid_amount), 65000);
        drive(mk_in(1,0,0,0,4'b0010,0,1000,0,0));
        step();
        check("ovf_err",   int'(err_reject), 1);
        check("ovf_paid2", int'(paid_amount), 65000);
        check("ovf_acc",   int'(tender_accept), 0);
        drive(mk_in(1,0,0,1,4'b0000,0,0,0,0));
        step();
        drive(mk_in(1,0,0,0,4'b0000,0,0,0,0));
        step();

        // Timeout after a partial payment.
        drive(mk_in(1,1,100,0,4'b0000,0,0,0,0));
        step();
        drive(mk_in(1,0,0,0,4'b0001,20,0,0,0));
        step();
        check("to_paid", int'(paid_amount), 20);
        drive(mk_in(1,0,0,0,4'b0000,0,0,0,0));
        n = 0;
        while (!line_disconnected && n < int'(TIMEOUT) + 5) begin
            step();
            n++;
        end
        check("to_cycles", n, int'(TIMEOUT));
        check("to_busy",   int'(busy), 1);
        check("to_ready",  int'(tender_ready), 0);
        check("to_refund", int'(change_amount), CHG ? 20 : 0);
        step();
        check("to_idle", int'(busy), 0);
        check("to_hold", int'(line_disconnected), 1);
        drive(mk_in(1,1,50,0,4'b0000,0,0,0,0));
        step();
        check("to_clear", int'(line_disconnected), 0);
        check("to_rem",   int'(remaining_amount), 50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
